fp_scoreboard_multi: RTL
========================

Name: fp_scoreboard_multi

Overview:
- Parametrised successor to the single-bit FP busy tracker: a per-register pending-write scoreboard for the FP register file.
- Each register holds an up/down pending counter, so several in-flight writes to the same rd can be outstanding at once.
- Supports NUM_SRC source operands, NUM_WB write-back ports, and a kill port for instructions squashed inside pipelined or multi-cycle FP units.
- Sits between decode (issue check) and the FP write-back / unit-completion paths.

Parameters:
- NUM_REGS, 32: number of FP architectural registers; power of two, at least 2.
- NUM_SRC, 3: source operands checked per issue (rs1/rs2/rs3).
- NUM_WB, 2: write-back ports that retire pending writes in the same cycle.
- CNT_W, 2: pending-counter width; max outstanding writes per register = 2^CNT_W - 1.
- NUM_PROBE, 3: number of unit-rd probe ports (replaces the all_uu_FP_rd check).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction in ID wants to issue
- issue_wr  in  1  issuing instruction writes an FP rd
- issue_rd  in  log2(NUM_REGS)  destination address
- issue_src_addr  in  NUM_SRC x log2(NUM_REGS)  source addresses
- issue_src_used  in  NUM_SRC  per-source enable (clear for integer/unused sources)
- issue_cancel  in  1  branch hazard; suppresses the counter increment
- issue_stall  out  1  issue must be held this cycle
- issue_fire  out  1  issue accepted; rd counter increments
- wb_valid  in  NUM_WB  write-back strobe per port
- wb_addr  in  NUM_WB x log2(NUM_REGS)  write-back rd per port
- kill_valid  in  1  in-unit instruction squashed
- kill_rd  in  log2(NUM_REGS)  rd of the squashed instruction
- probe_addr  in  NUM_PROBE x log2(NUM_REGS)  unit rd probes
- probe_busy  out  NUM_PROBE  pending counter of the probed register is non-zero
- src_busy  out  NUM_SRC  per-source busy
- busy_vec  out  NUM_REGS  per-register counter non-zero
- any_busy  out  1  OR of busy_vec
- underflow_err  out  1  sticky: a decrement hit a zero counter

Behaviour:
- Reset (asynchronous, reset_n low): all counters = 0 and underflow_err = 0. Consequently busy_vec = 0, any_busy = 0, src_busy = 0, probe_busy = 0, issue_stall = 0, issue_fire = 0.
- All status outputs are combinational from the current counter state; no bypass from same-cycle write-backs (a write-back clears busy from the next cycle).
- src_busy[k] = issue_src_used[k] AND (cnt[issue_src_addr[k]] != 0).
- issue_stall = issue_valid AND (OR of src_busy, OR issue_wr AND cnt[issue_rd] at max).
- issue_fire = issue_valid AND NOT issue_stall AND issue_wr AND NOT issue_cancel.
- Per-register next count = cnt + inc - dec.
  - inc = 1 if issue_fire targets the register.
  - dec = number of wb_valid ports addressing it, plus 1 if kill_valid addresses it.
- Result is computed at CNT_W+2 bits and the update is applied in one cycle.
- Simultaneous increment and decrement on the same register: net effect only (count unchanged for 1+1).
- Duplicate wb_addr across ports, or wb plus kill on the same register, decrement by the total.
- Underflow (decrement exceeds count): counter clamps to 0 and underflow_err sets; it stays set until reset.
- Overflow cannot occur: issue stalls at the max count.
- Register 0 is tracked like any other register (FP f0 is a real register).
- Reset asserted mid-operation drops all pending state immediately; in-flight write-backs arriving after reset release are then underflows and are flagged.

Optional Feature:
- Macro: FP_SCB_WAW_STALL_EN.
- Defined: issue_stall additionally asserts when issue_wr AND cnt[issue_rd] != 0, so at most one outstanding write per register (strict WAW ordering); counters effectively hold 0 or 1.
- Undefined: multiple outstanding writes per register up to the max count, and the stall applies only at max.

Decomposition:
- Package fp_scb_pkg holds:
  - localparam REG_AW = $clog2(NUM_REGS) defaults;
  - typedef reg_addr_t;
  - typedef cnt_t;
  - function for the population count of matching write-back ports.
- Sub-module fp_scb_counter: one saturating up/down counter with inc, dec-count, zero flag and underflow pulse, instantiated NUM_REGS times in a generate loop.

Test Plan:
- Reset, then issue rd=5 (no sources busy), then src rs1=5 next cycle -> issue_fire=1; next cycle busy_vec[5]=1 and src_busy[0]=1, issue_stall=1; wb_valid[0] to 5 -> following cycle stall=0.
- Issue rd=7 three times (CNT_W=2) -> count reaches 3; a fourth issue to rd=7 gives issue_stall=1 and issue_fire=0; one wb to 7 -> count 2 and the fourth issue fires.
- Same cycle: issue_fire rd=3 with wb_valid[1] to 3 while count=1 -> count stays 1; wb_valid[0] and wb_valid[1] both to 3 with count=2 -> count 0.
- issue_cancel=1 with a valid non-stalled issue to rd=9 -> issue_fire=0 and busy_vec[9]=0; kill_valid rd=9 on count=1 -> count 0, no error.
- wb to rd=12 with count 0 -> count stays 0 and underflow_err=1 persistently; reset_n low mid-traffic -> all counters and underflow_err 0 asynchronously.
- With FP_SCB_WAW_STALL_EN: rd=4 pending, issue rd=4 with no busy sources -> issue_stall=1. Without the macro -> fires and count becomes 2.

Source files
------------

// File: rtl/fp_scb_pkg.sv
// Shared types and helpers for the FP pending-write scoreboard (fp_scoreboard_multi).
// Widths here are the default configuration; the top derives its own from its parameters.
package fp_scb_pkg;

    localparam int NUM_REGS_DEF    = 32;
    localparam int REG_AW          = $clog2(NUM_REGS_DEF);
    localparam int CNT_W_DEF       = 2;
    localparam int MAX_MATCH_PORTS = 16;
    localparam int DEC_W           = $clog2(MAX_MATCH_PORTS + 2) + 1;

    typedef logic [REG_AW-1:0]          reg_addr_t;
    typedef logic [CNT_W_DEF-1:0]       cnt_t;
    typedef logic [MAX_MATCH_PORTS-1:0] match_vec_t;
    typedef logic [DEC_W-1:0]           dec_t;

    // Number of write-back ports whose address matched one register.
    function automatic dec_t count_matches(input match_vec_t hits);
        dec_t n;
        n = '0;
        for (int i = 0; i < MAX_MATCH_PORTS; i++) begin
            n = n + {{(DEC_W-1){1'b0}}, hits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_scb_counter.sv
// One pending-write counter: +1 on issue, -N on write-back/kill, clamps at 0 and max.
// Reports zero/full status and a one-cycle underflow pulse.
module fp_scb_counter
    import fp_scb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  dec_t             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             full,
    output logic             underflow
);

    localparam int EXT_W = (CNT_W + 2 > DEC_W + 1) ? CNT_W + 2 : DEC_W + 1;
    localparam logic [EXT_W-1:0] MAX_EXT = {{(EXT_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EXT_W-1:0] sum_ext, dec_ext, res_ext;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        sum_ext   = {{(EXT_W-CNT_W){1'b0}}, cnt_q} + {{(EXT_W-1){1'b0}}, inc};
        dec_ext   = {{(EXT_W-DEC_W){1'b0}}, dec};
        res_ext   = sum_ext - dec_ext;
        underflow = (dec_ext > sum_ext);
        if (underflow) begin
            cnt_d = '0;
        end else if (res_ext > MAX_EXT) begin
            cnt_d = '1;
        end else begin
            cnt_d = res_ext[CNT_W-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so all counters update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign full = (cnt_q == '1);

endmodule

// File: rtl/fp_scoreboard_multi.sv
// Per-register FP pending-write scoreboard with multi-port write-back, kill and unit probes.
// Optional macro FP_SCB_WAW_STALL_EN: stall any write to a register that is already pending.
module fp_scoreboard_multi
    import fp_scb_pkg::*;
#(
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int NUM_SRC   = 3,
    parameter int NUM_WB    = 2,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int NUM_PROBE = 3
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     issue_valid,
    input  logic                                     issue_wr,
    input  logic [$clog2(NUM_REGS)-1:0]              issue_rd,
    input  logic [NUM_SRC-1:0][$clog2(NUM_REGS)-1:0] issue_src_addr,
    input  logic [NUM_SRC-1:0]                       issue_src_used,
    input  logic                                     issue_cancel,
    output logic                                     issue_stall,
    output logic                                     issue_fire,
    input  logic [NUM_WB-1:0]                        wb_valid,
    input  logic [NUM_WB-1:0][$clog2(NUM_REGS)-1:0]  wb_addr,
    input  logic                                     kill_valid,
    input  logic [$clog2(NUM_REGS)-1:0]              kill_rd,
    input  logic [NUM_PROBE-1:0][$clog2(NUM_REGS)-1:0] probe_addr,
    output logic [NUM_PROBE-1:0]                     probe_busy,
    output logic [NUM_SRC-1:0]                       src_busy,
    output logic [NUM_REGS-1:0]                      busy_vec,
    output logic                                     any_busy,
    output logic                                     underflow_err
);

    localparam int AW = $clog2(NUM_REGS);
    typedef logic [AW-1:0] addr_t;

    logic [NUM_REGS-1:0] full_vec;
    logic [NUM_REGS-1:0] uflow_vec;
    logic                waw_block;
    logic                underflow_err_q, underflow_err_d;

    // Issue check sees only registered counter state: a same-cycle write-back does not bypass.
    always_comb begin
        src_busy   = '0;
        probe_busy = '0;
        waw_block  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_busy[k] = issue_src_used[k] & busy_vec[issue_src_addr[k]];
        end
        for (int p = 0; p < NUM_PROBE; p++) begin
            probe_busy[p] = busy_vec[probe_addr[p]];
        end
`ifdef FP_SCB_WAW_STALL_EN
        waw_block = issue_wr & busy_vec[issue_rd];
`else
        waw_block = 1'b0;
`endif
        issue_stall = issue_valid &
                      ((|src_busy) | (issue_wr & full_vec[issue_rd]) | waw_block);
        issue_fire  = issue_valid & ~issue_stall & issue_wr & ~issue_cancel;
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        match_vec_t       hits;
        logic             kill_hit;
        logic             inc;
        dec_t             dec;
        logic [CNT_W-1:0] cnt;
        logic             zero;

        always_comb begin
            hits = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                hits[p] = wb_valid[p] & (wb_addr[p] == addr_t'(r));
            end
            kill_hit = kill_valid & (kill_rd == addr_t'(r));
            inc      = issue_fire & (issue_rd == addr_t'(r));
            dec      = count_matches(hits) + {{(DEC_W-1){1'b0}}, kill_hit};
        end

        fp_scb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (inc),
            .dec       (dec),
            .cnt       (cnt),
            .zero      (zero),
            .full      (full_vec[r]),
            .underflow (uflow_vec[r])
        );

        assign busy_vec[r] = ~zero;
    end

    assign any_busy        = |busy_vec;
    assign underflow_err_d = underflow_err_q | (|uflow_vec);

    // NOTE: the sticky error flag is cleared only by reset; counters reset alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_err_q <= 1'b0;
        end else begin
            underflow_err_q <= underflow_err_d;
        end
    end

    assign underflow_err = underflow_err_q;

endmodule
